// File: rtl/jam_pkg.sv
// Shared types and width helpers for the jam_search_param assignment search engine.
package jam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        CMP,
        PIVOT,
        SWAP_SCAN,
        SWAP,
        REVERSE,
        DONE
    } state_t;

    localparam int MAX_N      = 8;
    localparam int MAX_IDX_W  = 3;
    localparam int MAX_FLAT_W = MAX_N * MAX_IDX_W;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    function automatic int sum_width(input int cost_w, input int n);
        return cost_w + $clog2(n);
    endfunction

    // Packed identity permutation: entry i holds value i.
    function automatic logic [MAX_FLAT_W-1:0] identity_flat(input int n, input int w);
        logic [MAX_FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < n; i++)
            f = f | (MAX_FLAT_W'(i) << (i * w));
        return f;
    endfunction

    // True when the packed permutation is N-1, N-2, ..., 0 (the final one).
    function automatic logic is_descending(input logic [MAX_FLAT_W-1:0] flat,
                                           input int n, input int w);
        logic                  ok;
        logic [MAX_FLAT_W-1:0] mask;
        ok   = 1'b1;
        mask = (MAX_FLAT_W'(1) << w) - MAX_FLAT_W'(1);
        for (int i = 0; i < n; i++)
            if (((flat >> (i * w)) & mask) != MAX_FLAT_W'(n - 1 - i))
                ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/jam_search_param_perm_next.sv
// Permutation register plus next-lexicographic-permutation sequencer
// (pivot scan, successor scan, swap, suffix reversal), one step per request.
module jam_perm_next
    import jam_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         init,
    input  logic                         step,
    output logic [N*idx_width(N)-1:0]    perm_flat,
    output logic                         done,
    output logic                         last
);
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] perm_reg [N];
    logic [IDX_W-1:0] p_reg, k_reg, idx_reg, lo_reg, hi_reg;
    logic [IDX_W-1:0] idx_inc;
    logic             rise;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_flat
            assign perm_flat[gi*IDX_W +: IDX_W] = perm_reg[gi];
        end
    endgenerate

    assign last    = is_descending(MAX_FLAT_W'(perm_flat), N, IDX_W);
    assign idx_inc = (idx_reg == TOP_IDX) ? TOP_IDX : idx_reg + 1'b1;
    assign rise    = perm_reg[idx_reg] < perm_reg[idx_inc];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_reg <= IDLE;
        else if (init)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (step) state_next = PIVOT;
            PIVOT:     if (rise) state_next = SWAP_SCAN;
            SWAP_SCAN: if (idx_reg == TOP_IDX) state_next = SWAP;
            SWAP:      state_next = REVERSE;
            REVERSE:   if (lo_reg >= hi_reg) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        done = (state_reg == REVERSE) && (lo_reg >= hi_reg);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N; i++)
                perm_reg[i] <= IDX_W'(i);
            p_reg   <= '0;
            k_reg   <= '0;
            idx_reg <= '0;
            lo_reg  <= '0;
            hi_reg  <= '0;
        end else if (init) begin
            for (int i = 0; i < N; i++)
                perm_reg[i] <= IDX_W'(i);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (step)
                        idx_reg <= IDX_W'(N - 2);
                end
                PIVOT: begin
                    if (rise) begin
                        p_reg   <= idx_reg;
                        k_reg   <= idx_inc;
                        idx_reg <= idx_inc;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                SWAP_SCAN: begin
                    // Keep the smallest value still above the pivot value.
                    if ((perm_reg[idx_reg] > perm_reg[p_reg]) &&
                        (perm_reg[idx_reg] < perm_reg[k_reg]))
                        k_reg <= idx_reg;
                    if (idx_reg != TOP_IDX)
                        idx_reg <= idx_reg + 1'b1;
                end
                SWAP: begin
                    perm_reg[p_reg] <= perm_reg[k_reg];
                    perm_reg[k_reg] <= perm_reg[p_reg];
                    lo_reg          <= p_reg + 1'b1;
                    hi_reg          <= TOP_IDX;
                end
                REVERSE: begin
                    if (lo_reg < hi_reg) begin
                        perm_reg[lo_reg] <= perm_reg[hi_reg];
                        perm_reg[hi_reg] <= perm_reg[lo_reg];
                        lo_reg           <= lo_reg + 1'b1;
                        hi_reg           <= hi_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jam_search_param.sv
// Exhaustive job-assignment search: sums Cost over every permutation, tracks minimum
// and tie count. Define JAM_BEST_PERM_EN to add the BestPerm output.
module jam_search_param
    import jam_pkg::*;
#(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             Start,
    output logic                             Busy,
    output logic [idx_width(N)-1:0]          W,
    output logic [idx_width(N)-1:0]          J,
    input  logic [COST_W-1:0]                Cost,
    output logic [sum_width(COST_W, N)-1:0]  MinCost,
    output logic [CNT_W-1:0]                 MatchCount,
    output logic                             Valid
`ifdef JAM_BEST_PERM_EN
    ,
    output logic [N*idx_width(N)-1:0]        BestPerm
`endif
);
    localparam int IDX_W = idx_width(N);
    localparam int SUM_W = sum_width(COST_W, N);
    localparam logic [IDX_W-1:0] LAST_W = IDX_W'(N - 1);
`ifdef JAM_BEST_PERM_EN
    localparam logic [N*IDX_W-1:0] IDENT_PERM = (N*IDX_W)'(identity_flat(N, IDX_W));
`endif

    state_t             state_reg, state_next;
    logic [SUM_W-1:0]   acc_reg;
    logic [N*IDX_W-1:0] perm_flat;
    logic [IDX_W-1:0]   perm_word [N];
    logic [IDX_W-1:0]   w_next;
    logic               start_ok, step_req, step_done, perm_last;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            assign perm_word[gi] = perm_flat[gi*IDX_W +: IDX_W];
        end
    endgenerate

    jam_perm_next #(.N(N)) u_perm (
        .CLK       (CLK),
        .RST       (RST),
        .init      (start_ok),
        .step      (step_req),
        .perm_flat (perm_flat),
        .done      (step_done),
        .last      (perm_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // PIVOT here covers the whole stepping sequence run inside u_perm.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (Start) state_next = ACCUM;
            ACCUM:      if (W == LAST_W) state_next = CMP;
            CMP:        state_next = perm_last ? DONE : PIVOT;
            PIVOT:      if (step_done) state_next = ACCUM;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy     = (state_reg != IDLE) && (state_reg != DONE);
        Valid    = (state_reg == DONE);
        start_ok = ((state_reg == IDLE) || (state_reg == DONE)) && Start;
        step_req = (state_reg == CMP) && !perm_last;
        w_next   = (W == LAST_W) ? '0 : W + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            W          <= '0;
            J          <= '0;
            acc_reg    <= '0;
            MinCost    <= '1;
            MatchCount <= '0;
`ifdef JAM_BEST_PERM_EN
            BestPerm   <= IDENT_PERM;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (Start) begin
                        W          <= '0;
                        J          <= '0;
                        acc_reg    <= '0;
                        MinCost    <= '1;
                        MatchCount <= '0;
`ifdef JAM_BEST_PERM_EN
                        BestPerm   <= IDENT_PERM;
`endif
                    end
                end
                ACCUM: begin
                    acc_reg <= acc_reg + SUM_W'(Cost);
                    W       <= w_next;
                    J       <= perm_word[w_next];
                end
                CMP: begin
                    if (acc_reg < MinCost) begin
                        MinCost    <= acc_reg;
                        MatchCount <= CNT_W'(1);
`ifdef JAM_BEST_PERM_EN
                        BestPerm   <= perm_flat;
`endif
                    end else if (acc_reg == MinCost) begin
                        if (MatchCount != '1)
                            MatchCount <= MatchCount + 1'b1;
                    end
                    acc_reg <= '0;
                end
                PIVOT: begin
                    if (step_done) begin
                        W <= '0;
                        J <= perm_word[0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_search_param.sv
// Directed bench for jam_search_param: three instances (N=4, N=3, N=6 with 8-bit counter).
module tb_jam_search_param;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // N=4 instance, cost from a programmable table
    logic       start4, busy4, valid4;
    logic [1:0] w4, j4;
    logic [6:0] cost4;
    logic [8:0] min4;
    logic [15:0] cnt4;
    logic [6:0] cost_tab [4][4];
    assign cost4 = cost_tab[w4][j4];

    // N=3 instance, zero cost only on the cyclic shift J=(W+1)%3
    logic       start3, busy3, valid3;
    logic [1:0] w3, j3;
    logic [6:0] cost3;
    logic [8:0] min3;
    logic [15:0] cnt3;
    assign cost3 = (int'(j3) == (int'(w3) + 1) % 3) ? 7'd0 : 7'd7;

    // N=6 instance with 8-bit saturating counter, unit cost everywhere
    logic       start6, busy6, valid6;
    logic [2:0] w6, j6;
    logic [6:0] cost6;
    logic [9:0] min6;
    logic [7:0] cnt6;
    assign cost6 = 7'd1;

`ifdef JAM_BEST_PERM_EN
    logic [7:0] best4;
    logic [5:0] best3;
    logic [17:0] best6;
`endif

    jam_search_param #(.N(4), .COST_W(7), .CNT_W(16)) u4 (
        .CLK(CLK), .RST(RST), .Start(start4), .Busy(busy4), .W(w4), .J(j4),
        .Cost(cost4), .MinCost(min4), .MatchCount(cnt4), .Valid(valid4)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(best4)
`endif
    );

    jam_search_param #(.N(3), .COST_W(7), .CNT_W(16)) u3 (
        .CLK(CLK), .RST(RST), .Start(start3), .Busy(busy3), .W(w3), .J(j3),
        .Cost(cost3), .MinCost(min3), .MatchCount(cnt3), .Valid(valid3)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(best3)
`endif
    );

    jam_search_param #(.N(6), .COST_W(7), .CNT_W(8)) u6 (
        .CLK(CLK), .RST(RST), .Start(start6), .Busy(busy6), .W(w6), .J(j6),
        .Cost(cost6), .MinCost(min6), .MatchCount(cnt6), .Valid(valid6)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(best6)
`endif
    );

    // Completed permutations: one per cycle spent at the last worker index.
    int pass4 = 0, pass3 = 0, pass6 = 0;
    always @(posedge CLK) begin
        if (busy4 && w4 == 2'd3) pass4 <= pass4 + 1;
        if (busy3 && w3 == 2'd2) pass3 <= pass3 + 1;
        if (busy6 && w6 == 3'd5) pass6 <= pass6 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic set_costs(input bit diag);
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++)
                cost_tab[w][j] = diag ? ((w == j) ? 7'd0 : 7'd10) : 7'd5;
    endtask

    task automatic pulse(input int which);
        @(negedge CLK);
        start4 = (which == 4);
        start3 = (which == 3);
        start6 = (which == 6);
        @(negedge CLK);
        start4 = 1'b0;
        start3 = 1'b0;
        start6 = 1'b0;
    endtask

    task automatic wait_valid(input int which, input int max_cycles);
        logic v;
        v = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            v = (which == 4) ? valid4 : (which == 3) ? valid3 : valid6;
            if (v) break;
            @(negedge CLK);
        end
        check($sformatf("valid%0d_seen", which), 32'(v), 32'd1);
    endtask

    int  snap;
    logic hit;

    initial begin
        RST = 1'b1;
        start4 = 1'b0;
        start3 = 1'b0;
        start6 = 1'b0;
        set_costs(1'b0);
        repeat (3) @(negedge CLK);

        check("rst_busy",  32'(busy4),  32'd0);
        check("rst_valid", 32'(valid4), 32'd0);
        check("rst_w",     32'(w4),     32'd0);
        check("rst_j",     32'(j4),     32'd0);
        check("rst_min",   32'(min4),   32'd511);
        check("rst_cnt",   32'(cnt4),   32'd0);
`ifdef JAM_BEST_PERM_EN
        check("rst_best",  32'(best4),  32'd228);
`endif
        RST = 1'b0;

        // Uniform cost: every permutation ties at 4*5.
        snap = pass4;
        pulse(4);
        check("s1_busy", 32'(busy4), 32'd1);
        wait_valid(4, 5000);
        check("s1_min",    32'(min4),     32'd20);
        check("s1_cnt",    32'(cnt4),     32'd24);
        check("s1_passes", 32'(pass4 - snap), 32'd24);
        check("s1_idle",   32'(busy4),    32'd0);
`ifdef JAM_BEST_PERM_EN
        check("s1_best",   32'(best4),    32'd228);
`endif

        // New table without reset; extra Start pulses while busy are ignored.
        set_costs(1'b1);
        snap = pass4;
        pulse(4);
        check("s2_valid_drop", 32'(valid4), 32'd0);
        check("s2_busy",       32'(busy4),  32'd1);
        repeat (10) @(negedge CLK);
        pulse(4);
        repeat (40) @(negedge CLK);
        pulse(4);
        wait_valid(4, 5000);
        check("s2_min",    32'(min4), 32'd0);
        check("s2_cnt",    32'(cnt4), 32'd1);
        check("s2_passes", 32'(pass4 - snap), 32'd24);
`ifdef JAM_BEST_PERM_EN
        check("s2_best",   32'(best4), 32'd228);
`endif

        // Reset during accumulation of the 5th permutation (0,3,1,2).
        set_costs(1'b0);
        snap = pass4;
        pulse(4);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ((pass4 - snap) >= 4 && w4 == 2'd1) begin
                hit = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("s5_mid_j",  32'(j4), 32'd3);
        check("s5_reached", 32'(hit), 32'd1);
        RST = 1'b1;
        #1;
        check("s5_busy",  32'(busy4),  32'd0);
        check("s5_valid", 32'(valid4), 32'd0);
        check("s5_w",     32'(w4),     32'd0);
        check("s5_j",     32'(j4),     32'd0);
        check("s5_min",   32'(min4),   32'd511);
        check("s5_cnt",   32'(cnt4),   32'd0);
        @(negedge CLK);
        RST = 1'b0;
        snap = pass4;
        pulse(4);
        wait_valid(4, 5000);
        check("s5_rerun_min",    32'(min4), 32'd20);
        check("s5_rerun_cnt",    32'(cnt4), 32'd24);
        check("s5_rerun_passes", 32'(pass4 - snap), 32'd24);

        // N=3 cyclic shift: unique zero-cost assignment 1,2,0.
        snap = pass3;
        pulse(3);
        wait_valid(3, 2000);
        check("n3_min",    32'(min3), 32'd0);
        check("n3_cnt",    32'(cnt3), 32'd1);
        check("n3_passes", 32'(pass3 - snap), 32'd6);
`ifdef JAM_BEST_PERM_EN
        check("n3_best",   32'(best3), 32'd9);
`endif

        // N=6 unit cost: 720 ties saturate the 8-bit counter.
        snap = pass6;
        pulse(6);
        wait_valid(6, 40000);
        check("n6_min",    32'(min6), 32'd6);
        check("n6_cnt",    32'(cnt6), 32'd255);
        check("n6_passes", 32'(pass6 - snap), 32'd720);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jam_search_param.md
Name: jam_search_param

Overview:
- Parametrised job-assignment search engine; successor to the fixed 8x8 assignment solver.
- Exhaustively enumerates all N! worker-to-job permutations in lexicographic order.
- Reads each cost through the external W/J -> Cost lookup and reports the minimum total cost and the number of permutations achieving it.
- Adds a Start/Busy/Valid handshake, so a new search runs without reset, and a saturating match counter.

Parameters:
- N, 8, worker/job count; legal range 2..8.
- COST_W, 7, width of one Cost entry.
- CNT_W, 16, width of MatchCount (saturating).
- Derived, not overridable: IDX_W = $clog2(N); SUM_W = COST_W + $clog2(N).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- Start  input  1  begin search; sampled only in IDLE or DONE.
- Busy  output  1  high while a search is in progress.
- W  output  IDX_W  worker index for cost lookup.
- J  output  IDX_W  job index for cost lookup.
- Cost  input  COST_W  cost of (W,J); combinational, valid in the same cycle as W/J.
- MinCost  output  SUM_W  minimum total cost found.
- MatchCount  output  CNT_W  number of permutations with total == MinCost.
- Valid  output  1  results final; held until next Start.

Behaviour:
- Reset values:
  - State IDLE.
  - Busy=0, Valid=0, W=0, J=0.
  - MinCost = all ones; MatchCount = 0.
  - perm[i] = i; accumulator = 0.
- States: IDLE, ACCUM, CMP, PIVOT, SWAP_SCAN, SWAP, REVERSE, DONE.
- IDLE/DONE, Start=1:
  - Load perm[i]=i, MinCost = all ones, MatchCount=0, accumulator=0.
  - Drive W=0, J=perm[0]; Valid <= 0, Busy <= 1; go to ACCUM.
- ACCUM (exactly N cycles per permutation):
  - Each cycle: acc += Cost, zero-extended to SUM_W; W increments; J <= perm[W+1].
  - After the cycle with W=N-1, go to CMP.
- CMP (1 cycle):
  - acc < MinCost: MinCost <= acc, MatchCount <= 1.
  - acc == MinCost: MatchCount <= MatchCount+1, saturating at 2^CNT_W-1.
  - Otherwise: no change.
  - Then clear acc.
  - If perm is descending (perm[i] = N-1-i for all i): go to DONE.
  - Else: go to PIVOT.
- PIVOT: scan from index N-2 downward, one index per cycle, for the largest p with perm[p] < perm[p+1].
- SWAP_SCAN: scan p+1..N-1 for the smallest perm[k] > perm[p]; one index per cycle.
- SWAP (1 cycle): exchange perm[p] and perm[k].
- REVERSE:
  - Reverse perm[p+1..N-1], one pair per cycle (lo++, hi--) until lo >= hi.
  - Then W <= 0, J <= new perm[0]; go to ACCUM.
- DONE: Busy=0, Valid=1; MinCost and MatchCount stable.
- Total permutations evaluated: exactly N!. The first permutation is identity, the last is descending.
- Arithmetic:
  - No overflow of acc, since N*(2^COST_W-1) < 2^SUM_W.
  - A total of exactly all ones still replaces the initial MinCost sentinel and sets MatchCount=1, because the first permutation always ties or beats it.
- Start while Busy: ignored.
- Start in the same cycle as RST: RST wins.
- Reset mid-search: all state and outputs return to reset values immediately; no partial result is reported.
- Cost is ignored outside ACCUM.

Optional Feature:
- Macro: JAM_BEST_PERM_EN.
- Defined:
  - Extra output BestPerm, N*IDX_W wide.
  - Entry i, at bits [i*IDX_W +: IDX_W], is the job assigned to worker i.
  - Updated in CMP only on strict improvement (acc < MinCost), so it holds the lexicographically first optimal permutation.
  - Reset value: identity.
- Undefined: port and storage absent; all other behaviour identical.

Decomposition:
- Package jam_pkg holds:
  - state enum;
  - function clog2-based width helpers;
  - descending-check function;
  - SUM_W/IDX_W derivation helpers.
- One sub-module is natural: jam_perm_next.
  - Owns the perm register array and the PIVOT/SWAP_SCAN/SWAP/REVERSE sequencing.
  - Handshake: step request in, done/last flags out.
  - The top module keeps the accumulator, comparator and handshake.

Test Plan:
- N=4, Cost=5 for all (W,J), Start -> Valid after full run; MinCost=20, MatchCount=24; the bench counts exactly 24 ACCUM passes.
- N=4, Cost=(W==J)?0:10 -> MinCost=0, MatchCount=1; with JAM_BEST_PERM_EN, BestPerm = identity {3,2,1,0} packed.
- N=8, COST_W=7, CNT_W=8, Cost=1 everywhere -> MinCost=8, MatchCount=255 (saturated, true count 40320).
- N=3, Cost=(J==(W+1)%3)?0:7 -> MinCost=0, MatchCount=1, BestPerm={0,2,1} (worker0->job1, worker1->job2, worker2->job0).
- N=4, assert RST mid-ACCUM of the 5th permutation -> outputs at reset values the same cycle; Start then runs a clean search matching the first scenario.
- After Valid, change the cost table and pulse Start without reset -> Valid drops next cycle, Busy=1, new results correct; Start pulses during Busy have no effect.
